// File: rtl/operand_fetch.sv
// Operand fetch: regfile read, writeback bypass, scoreboard hazards,
// and one registered operand bundle toward execute.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_we,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_rd_we
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;
  logic            rs1_nz;
  logic            rs2_nz;
  logic            rd_nz;
  logic            wb_nz;
  logic            hit1;
  logic            hit2;
  logic            raw1;
  logic            raw2;
  logic            waw;
  logic            issue;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign rf_rs1 = id_rs1;
  assign rf_rs2 = id_rs2;

  assign rs1_nz = (id_rs1 != '0);
  assign rs2_nz = (id_rs2 != '0);
  assign rd_nz  = (id_rd != '0);
  assign wb_nz  = (wb_rd != '0);

  assign hit1 = wb_we && (wb_rd == id_rs1) && rs1_nz;
  assign hit2 = wb_we && (wb_rd == id_rs2) && rs2_nz;

  assign raw1 = id_use_rs1 && rs1_nz
             && pending[id_rs1] && !hit1;
  assign raw2 = id_use_rs2 && rs2_nz
             && pending[id_rs2] && !hit2;
  assign waw  = id_rd_we && rd_nz && pending[id_rd]
             && !(wb_we && (wb_rd == id_rd));

  assign id_ready = rst && !flush
                 && !raw1 && !raw2 && !waw
                 && (!ex_valid || ex_ready);
  assign issue = id_valid && id_ready;

  always_comb begin
    op1 = rf_rs1_data;
    if (!rs1_nz)   op1 = '0;
    else if (hit1) op1 = wb_data;
  end

  always_comb begin
    op2 = rf_rs2_data;
    if (!rs2_nz)   op2 = '0;
    else if (hit2) op2 = wb_data;
  end

  // A new issue to the same register outranks the writeback clear.
  always_comb begin
    pend_nxt = pending;
    if (wb_we && wb_nz)
      pend_nxt[wb_rd] = 1'b0;
    if (issue && id_rd_we && rd_nz)
      pend_nxt[id_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending     <= '0;
      ex_valid    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd       <= '0;
      ex_rd_we    <= 1'b0;
    end else if (flush) begin
      pending  <= '0;
      ex_valid <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (issue) begin
        ex_valid    <= 1'b1;
        ex_rs1_data <= op1;
        ex_rs2_data <= op2;
        ex_rd       <= id_rd;
        ex_rd_we    <= id_rd_we;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [AW-1:0]   id_rd;
  logic            id_rd_we;
  logic [AW-1:0]   rf_rs1;
  logic [AW-1:0]   rf_rs2;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [AW-1:0]   ex_rd;
  logic            ex_rd_we;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rd_we(id_rd_we),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2,
                       input logic [AW-1:0] rd, input logic we);
    id_valid = 1'b1;
    id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_rd_we = we;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
    rf_rs1_data = 32'h1; rf_rs2_data = 32'h2;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    step(); step();
    tests++; if (id_ready !== 1'b0) begin fails++;
      $display("FAIL reset_id_ready got %b exp 0", id_ready); end
    tests++; if (ex_valid !== 1'b0) begin fails++;
      $display("FAIL reset_ex_valid got %b exp 0", ex_valid); end
    tests++; if ({ex_rd_we, ex_rd, ex_rs1_data} !== '0) begin fails++;
      $display("FAIL reset_ex_regs got %b %h %h exp 0",
               ex_rd_we, ex_rd, ex_rs1_data); end
    tests++; if (dut.pending !== 32'h0) begin fails++;
      $display("FAIL reset_pending got %h exp 0", dut.pending); end
    id_valid = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1);
    rf_rs1_data = 32'h11; rf_rs2_data = 32'h22;
    #1;
    tests++; if ({rf_rs1, rf_rs2} !== {5'd3, 5'd4}) begin fails++;
      $display("FAIL basic_rf_addr got %0d/%0d exp 3/4", rf_rs1, rf_rs2); end
    tests++; if (id_ready !== 1'b1) begin fails++;
      $display("FAIL basic_id_ready got %b exp 1", id_ready); end
    step();
    id_valid = 1'b0;
    tests++; if (ex_valid !== 1'b1) begin fails++;
      $display("FAIL basic_ex_valid got %b exp 1", ex_valid); end
    tests++; if ({ex_rs1_data, ex_rs2_data} !== {32'h11, 32'h22}) begin fails++;
      $display("FAIL basic_data got %h/%h exp 11/22", ex_rs1_data, ex_rs2_data); end
    tests++; if ({ex_rd, ex_rd_we} !== {5'd5, 1'b1}) begin fails++;
      $display("FAIL basic_rd got %0d/%b exp 5/1", ex_rd, ex_rd_we); end
    tests++; if (dut.pending !== 32'h20) begin fails++;
      $display("FAIL basic_pending got %h exp 20", dut.pending); end
  endtask

  task automatic test_raw_bypass();
    instr(5'd5, 1'b1, 5'd1, 1'b0, 5'd6, 1'b1);
    rf_rs1_data = 32'h55;
    #1;
    tests++; if (id_ready !== 1'b0) begin fails++;
      $display("FAIL raw_stall got %b exp 0", id_ready); end
    step();
    tests++; if (ex_valid !== 1'b0) begin fails++;
      $display("FAIL raw_drain got %b exp 0", ex_valid); end
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++;
      $display("FAIL raw_release got %b exp 1", id_ready); end
    step();
    id_valid = 1'b0; wb_we = 1'b0;
    tests++; if (ex_rs1_data !== 32'hABCD) begin fails++;
      $display("FAIL raw_bypass got %h exp abcd", ex_rs1_data); end
    tests++; if (dut.pending !== 32'h40) begin fails++;
      $display("FAIL raw_pending got %h exp 40", dut.pending); end
  endtask

  task automatic test_x0();
    instr(5'd0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1);
    rf_rs1_data = 32'hFFFF; rf_rs2_data = 32'h77;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++;
      $display("FAIL x0_ready got %b exp 1", id_ready); end
    step();
    id_valid = 1'b0; wb_we = 1'b0;
    tests++; if ({ex_rs1_data, ex_rs2_data} !== {32'h0, 32'h77}) begin fails++;
      $display("FAIL x0_data got %h/%h exp 0/77", ex_rs1_data, ex_rs2_data); end
    tests++; if (dut.pending !== 32'h40) begin fails++;
      $display("FAIL x0_pending got %h exp 40", dut.pending); end
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    instr(5'd8, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1);
    rf_rs1_data = 32'h88; rf_rs2_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (id_ready !== 1'b0) begin fails++;
        $display("FAIL bp_ready[%0d] got %b exp 0", i, id_ready); end
      step();
      tests++; if ({ex_valid, ex_rs2_data, ex_rd} !== {1'b1, 32'h77, 5'd0})
        begin fails++;
        $display("FAIL bp_stable[%0d] got %b %h %0d exp 1 77 0",
                 i, ex_valid, ex_rs2_data, ex_rd); end
    end
    ex_ready = 1'b1;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++;
      $display("FAIL bp_release got %b exp 1", id_ready); end
    step();
    id_valid = 1'b0;
    tests++; if ({ex_valid, ex_rs1_data, ex_rs2_data, ex_rd} !==
                 {1'b1, 32'h88, 32'h99, 5'd10}) begin fails++;
      $display("FAIL bp_load got %b %h %h %0d exp 1 88 99 10",
               ex_valid, ex_rs1_data, ex_rs2_data, ex_rd); end
  endtask

  task automatic test_flush();
    instr(5'd1, 1'b0, 5'd1, 1'b0, 5'd7, 1'b1);
    step();
    instr(5'd7, 1'b1, 5'd1, 1'b0, 5'd11, 1'b1);
    #1;
    tests++; if (id_ready !== 1'b0) begin fails++;
      $display("FAIL fl_raw7 got %b exp 0", id_ready); end
    flush = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd12; wb_data = 32'h5;
    #1;
    tests++; if (id_ready !== 1'b0) begin fails++;
      $display("FAIL fl_ready got %b exp 0", id_ready); end
    step();
    flush = 1'b0; wb_we = 1'b0;
    tests++; if ({ex_valid, dut.pending} !== {1'b0, 32'h0}) begin fails++;
      $display("FAIL fl_clear got %b %h exp 0 0", ex_valid, dut.pending); end
    rf_rs1_data = 32'h70;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++;
      $display("FAIL fl_accept got %b exp 1", id_ready); end
    step();
    id_valid = 1'b0;
    tests++; if ({ex_valid, ex_rd, ex_rs1_data} !== {1'b1, 5'd11, 32'h70})
      begin fails++;
      $display("FAIL fl_issue got %b %0d %h exp 1 11 70",
               ex_valid, ex_rd, ex_rs1_data); end
  endtask

  task automatic test_waw();
    instr(5'd1, 1'b0, 5'd1, 1'b0, 5'd11, 1'b1);
    #1;
    tests++; if (id_ready !== 1'b0) begin fails++;
      $display("FAIL waw_stall got %b exp 0", id_ready); end
    wb_we = 1'b1; wb_rd = 5'd11; wb_data = 32'h0;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++;
      $display("FAIL waw_release got %b exp 1", id_ready); end
    step();
    id_valid = 1'b0; wb_we = 1'b0;
    tests++; if (dut.pending !== 32'h800) begin fails++;
      $display("FAIL waw_set_wins got %h exp 800", dut.pending); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] rds [3];
    rds[0] = 5'd13; rds[1] = 5'd14; rds[2] = 5'd15;
    for (int i = 0; i < 3; i++) begin
      instr(5'd2, 1'b1, 5'd3, 1'b1, rds[i], 1'b1);
      step();
      tests++; if ({ex_valid, ex_rd} !== {1'b1, rds[i]}) begin fails++;
        $display("FAIL b2b[%0d] got %b %0d exp 1 %0d",
                 i, ex_valid, ex_rd, rds[i]); end
    end
    id_valid = 1'b0;
    step();
    tests++; if (ex_valid !== 1'b0) begin fails++;
      $display("FAIL b2b_drain got %b exp 0", ex_valid); end
    tests++; if (dut.pending !== 32'h0000_E800) begin fails++;
      $display("FAIL b2b_pending got %h exp e800", dut.pending); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw_bypass();
    test_x0();
    test_backpressure();
    test_flush();
    test_waw();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
